// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute controller for the accumulator CPU.
//   Fetches a 16-bit instruction from the ROM, evaluates its conditional
//   execute bits against FLAG, drives the shared ALU and writes the result
//   back to ACC and/or ANS. Every instruction takes FETCH, WAIT, EXEC
//   (3 cycles). All architectural state (pc, acc, ans, flag, instr) lives here.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  run pulse, honoured only in IDLE or HALT
//   rom_addr/rom_en/rom_data  ROM read port (data valid one cycle after rom_en)
//   alu_a/alu_b/alu_op     ALU operands (acc, immediate) and op select
//   alu_o/alu_flag         combinational ALU result and flag
//   acc/ans/flag/pc        architectural state
//   busy/halted/retired    status; retired pulses once per instruction in EXEC
module cpu_sequencer #(
    parameter int ROM_SIZE  = 8,
    parameter int WORD_SIZE = 8,
    localparam int PCW = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [PCW-1:0]       rom_addr,
    output logic                 rom_en,
    input  logic [15:0]          rom_data,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [1:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_o,
    input  logic                 alu_flag,
    output logic [WORD_SIZE-1:0] acc,
    output logic [WORD_SIZE-1:0] ans,
    output logic                 flag,
    output logic [PCW-1:0]       pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT
    } state_t;

    localparam logic [1:0] OP_HALT = 2'd3;

    state_t               state_q, state_d;
    logic [PCW-1:0]       pc_q, pc_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;
    logic [WORD_SIZE-1:0] ans_q, ans_d;
    logic                 flag_q, flag_d;
    logic [15:0]          instr_q, instr_d;

    // Instruction fields
    logic       exec_if_flag, exec_if_not_flag, flag_set, exe;
    logic [1:0] op, wb;
    logic       instr_unused;
    logic [PCW-1:0] pc_inc;

    assign exec_if_flag     = instr_q[15];
    assign exec_if_not_flag = instr_q[14];
    assign flag_set         = instr_q[13];
    assign op               = instr_q[12:11];
    assign wb               = instr_q[10:9];
    assign instr_unused     = instr_q[8];

    // Both condition bits set can never be satisfied.
    assign exe = !(exec_if_flag && !flag_q) && !(exec_if_not_flag && flag_q);

    // Explicit wrap so a non power-of-two ROM_SIZE still wraps correctly.
    assign pc_inc = (pc_q == PCW'(ROM_SIZE - 1)) ? '0 : pc_q + PCW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            ans_q   <= '0;
            flag_q  <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ans_q   <= ans_d;
            flag_q  <= flag_d;
            instr_q <= instr_d;
        end
    end

    // Next state and architectural updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ans_d   = ans_q;
        flag_d  = flag_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH;
            S_FETCH:        state_d = S_WAIT;
            S_WAIT: begin
                instr_d = rom_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;   // skipped and HALT instructions advance too
                if (exe) begin
                    if (op == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        // ALU sees old acc this cycle; new value lands at the edge.
                        if (wb[0])    acc_d  = alu_o;
                        if (wb[1])    ans_d  = alu_o;
                        if (flag_set) flag_d = alu_flag;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        rom_en  = (state_q == S_FETCH);
        busy    = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_EXEC);
        halted  = (state_q == S_HALT);
        retired = (state_q == S_EXEC);
    end

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign acc      = acc_q;
    assign ans      = ans_q;
    assign flag     = flag_q;
    assign alu_a    = acc_q;
    assign alu_b    = WORD_SIZE'(instr_q[7:0]);
    assign alu_op   = op;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a ROM and ALU around the DUT, an instruction-level
// reference model advanced each clock, a per-cycle compare process, directed
// scenarios with literal expectations, then randomized programs.
module tb_cpu_sequencer;
    localparam int ROM_SIZE = 8;
    localparam int WORD_SIZE = 8;
    localparam int PCW = 3;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [PCW-1:0] rom_addr, pc;
    logic rom_en, alu_flag, flag, busy, halted, retired;
    logic [15:0] rom_data = 16'd0;
    logic [7:0] alu_a, alu_b, alu_o, acc, ans;
    logic [1:0] alu_op;
    logic [15:0] rom [ROM_SIZE];

    int n_cmp = 0, n_bad = 0, n_ret = 0;

    cpu_sequencer #(.ROM_SIZE(ROM_SIZE), .WORD_SIZE(WORD_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_o(alu_o), .alu_flag(alu_flag),
        .acc(acc), .ans(ans), .flag(flag), .pc(pc),
        .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // ALU: ADD carry, SUB borrow, XOR equal
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {a < b, 8'(a - b)};
            2'd2:    return {a == b, a ^ b};
            default: return 9'd0;
        endcase
    endfunction

    assign {alu_flag, alu_o} = alu_ref(alu_a, alu_b, alu_op);

    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    function automatic logic [15:0] mk(input bit eif, input bit einf, input bit fs,
                                       input int op, input int wb, input int imm);
        logic [1:0] o2, w2;
        logic [7:0] i8;
        o2 = 2'(op); w2 = 2'(wb); i8 = 8'(imm);
        return {eif, einf, fs, o2, w2, 1'b0, i8};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 halted; step = cycle within instruction.
    int m_mode = 0, m_step = 0, m_pc = 0;
    logic [7:0] m_acc = 0, m_ans = 0;
    logic m_flag = 0, m_exe;
    bit m_ok = 0;
    logic [15:0] m_w;
    logic [8:0] m_r;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_step = 0; m_pc = 0; m_acc = 0; m_ans = 0; m_flag = 0; m_ok = 1;
        end else if (m_mode != 1) begin
            if (start) begin m_mode = 1; m_step = 0; end
        end else if (m_step < 2) begin
            m_step++;
        end else begin
            m_w   = rom[m_pc];
            m_exe = !(m_w[15] && !m_flag) && !(m_w[14] && m_flag);
            m_r   = alu_ref(m_acc, m_w[7:0], m_w[12:11]);
            if (m_exe && m_w[12:11] == 2'd3) m_mode = 2;
            else if (m_exe) begin
                if (m_w[9])  m_acc  = m_r[7:0];
                if (m_w[10]) m_ans  = m_r[7:0];
                if (m_w[13]) m_flag = m_r[8];
            end
            m_pc   = (m_pc + 1) % ROM_SIZE;
            m_step = 0;
        end
    end

    // Per-cycle compare
    initial forever begin
        @(negedge clk);
        if (retired === 1'b1) n_ret++;
        if (m_ok) begin
            check("busy",     busy,     m_mode == 1);
            check("halted",   halted,   m_mode == 2);
            check("rom_en",   rom_en,   m_mode == 1 && m_step == 0);
            check("retired",  retired,  m_mode == 1 && m_step == 2);
            check("rom_addr", rom_addr, m_pc);
            check("pc",       pc,       m_pc);
            check("acc",      acc,      m_acc);
            check("ans",      ans,      m_ans);
            check("flag",     flag,     m_flag);
            if (m_mode == 1 && m_step == 2) begin
                check("alu_a",  alu_a,  m_acc);
                check("alu_b",  alu_b,  rom[m_pc][7:0]);
                check("alu_op", alu_op, rom[m_pc][12:11]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // Holds reset for one edge and clears the ROM while the core is idle.
    task automatic hold_reset();
        rst_n = 1'b0; start = 1'b0;
        tick(1);
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = 16'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic run_to_halt(input string nm);
        int k = 0;
        while (halted !== 1'b1 && k < 200) begin tick(1); k++; end
        check(nm, halted, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Basic ADD and reset state
        hold_reset();
        check("rst_busy", busy, 0); check("rst_acc", acc, 0); check("rst_pc", pc, 0);
        check("rst_rom_en", rom_en, 0); check("rst_halted", halted, 0);
        rom[0] = mk(0, 0, 0, 0, 1, 5);
        rst_n = 1'b1;
        pulse_start();
        tick(2);
        check("t1_retire_c3", retired, 1); check("t1_acc_old", acc, 0);
        tick(1);
        check("t1_acc", acc, 8'd5); check("t1_pc", pc, 1); check("t1_flag", flag, 0);

        // Carry into flag, then a skipped exec_if_not_flag
        hold_reset();
        rom[0] = mk(0, 0, 0, 0, 1, 8'hFF);
        rom[1] = mk(0, 0, 1, 0, 3, 1);
        rom[2] = mk(0, 1, 0, 0, 1, 7);
        rom[3] = mk(0, 0, 0, 3, 0, 0);
        rst_n = 1'b1; n_ret = 0;
        pulse_start();
        run_to_halt("t2_halt");
        check("t2_acc", acc, 0); check("t2_ans", ans, 0); check("t2_flag", flag, 1);
        check("t2_pc", pc, 4); check("t2_retires", n_ret, 4);

        // XOR equal flag, exec_if_flag SUB to ANS, both-bits skip
        hold_reset();
        rom[0] = mk(0, 0, 1, 2, 0, 0);
        rom[1] = mk(1, 0, 0, 1, 2, 1);
        rom[2] = mk(1, 1, 0, 0, 1, 5);
        rom[3] = mk(0, 0, 0, 3, 0, 0);
        rst_n = 1'b1;
        pulse_start();
        run_to_halt("t3_halt");
        check("t3_flag", flag, 1); check("t3_ans", ans, 8'hFF);
        check("t3_acc", acc, 0); check("t3_pc", pc, 4);

        // PC wrap, 8 instructions in 24 cycles
        hold_reset();
        for (int i = 0; i < ROM_SIZE; i++) rom[i] = mk(0, 0, 0, 0, 1, 1);
        rst_n = 1'b1; n_ret = 0;
        pulse_start();
        tick(24);
        check("t4_retires", n_ret, 8); check("t4_pc_wrap", pc, 0);
        check("t4_acc", acc, 8); check("t4_busy", busy, 1);

        // HALT and resume; start while busy is ignored
        hold_reset();
        rom[0] = mk(0, 0, 0, 0, 1, 8'hF0);
        rom[1] = mk(0, 0, 1, 0, 0, 8'h20);
        rom[2] = mk(0, 0, 0, 3, 0, 0);
        rom[3] = mk(0, 0, 0, 0, 1, 1);
        rom[4] = mk(0, 0, 0, 3, 0, 0);
        rst_n = 1'b1;
        pulse_start();
        tick(1);
        pulse_start();
        run_to_halt("t5_halt");
        check("t5_busy", busy, 0); check("t5_pc", pc, 3);
        check("t5_acc", acc, 8'hF0); check("t5_flag", flag, 1);
        tick(3);
        check("t5_still_halted", halted, 1);
        pulse_start();
        check("t5_resume_en", rom_en, 1); check("t5_resume_addr", rom_addr, 3);
        run_to_halt("t5_halt2");
        check("t5_acc2", acc, 8'hF1); check("t5_pc2", pc, 5);

        // Reset during WAIT, start held with reset
        hold_reset();
        rom[0] = mk(0, 0, 0, 0, 1, 8'h42);
        rst_n = 1'b1;
        pulse_start();
        tick(4);
        check("t6_acc_pre", acc, 8'h42); check("t6_pc_pre", pc, 1);
        rst_n = 1'b0; start = 1'b1;
        tick(1);
        check("t6_acc", acc, 0); check("t6_pc", pc, 0); check("t6_busy", busy, 0);
        check("t6_rom_en", rom_en, 0); check("t6_retired", retired, 0);
        tick(1);
        check("t6_start_in_rst", busy, 0);
        rst_n = 1'b1; start = 1'b0;
        tick(1);
        check("t6_idle", busy, 0);

        // Random programs, random start pulses, occasional reset
        repeat (40) begin
            hold_reset();
            for (int i = 0; i < ROM_SIZE; i++) begin
                rom[i] = 16'($urandom);
                if (rom[i][12:11] == 2'd3 && $urandom_range(0, 2) != 0) rom[i][12:11] = 2'd0;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 60; c++) begin
                start = ($urandom_range(0, 5) == 0);
                rst_n = ($urandom_range(0, 79) != 0);
                tick(1);
            end
        end
        start = 1'b0; rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
